// File: rtl/serial_ctrl_pkg.sv
// rtl/serial_ctrl_pkg.sv - shared constants and UART state encoding for serial_ctrl
package serial_ctrl_pkg;

  localparam int   SERIAL_CLKS_PER_BIT = 434;
  localparam logic MEM_WRITE           = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/serial_ctrl_if.sv
// rtl/serial_ctrl_if.sv - MMU-side data/status bus of the serial controller
interface serial_ctrl_if;

  logic       enable;
  logic       read_write;
  logic       fetch_data;
  logic [7:0] data_write;
  logic [7:0] data_read;
  logic       send_complete;
  logic       receive_complete;

  modport master (
    output enable, read_write, fetch_data, data_write,
    input  data_read, send_complete, receive_complete
  );

  modport slave (
    input  enable, read_write, fetch_data, data_write,
    output data_read, send_complete, receive_complete
  );

endinterface

// File: rtl/serial_ctrl_rx_fifo.sv
// rtl/serial_ctrl_rx_fifo.sv - receive byte FIFO with sticky overrun flag
module serial_ctrl_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       not_empty,
  output logic       overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop)
        overrun <= 1'b0;
      else if (push && !do_push)
        overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head      = empty ? 8'h00 : mem[rd_ptr];
  assign not_empty = ~empty;

endmodule

// File: rtl/serial_ctrl.sv
// rtl/serial_ctrl.sv - UART 8N1 controller: MMU writes become TX frames, RX bytes queue for reads
module serial_ctrl
  import serial_ctrl_pkg::*;
#(
  parameter int CLKS_PER_BIT = SERIAL_CLKS_PER_BIT,
  parameter int RX_DEPTH     = 4
) (
  input  logic         clk,
  input  logic         rst,
  serial_ctrl_if.slave bus,
  output logic         rx_overrun,
  output logic         uart_txd,
  input  logic         uart_rxd
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic wr_lvl, rd_lvl, wr_q, rd_q, wr_pulse, rd_pulse;

  uart_state_t   tx_state, tx_state_nxt;
  logic [CW-1:0] tx_cnt, tx_cnt_nxt;
  logic [2:0]    tx_bit, tx_bit_nxt;
  logic [7:0]    tx_byte, tx_byte_nxt;

  logic          rx_s1, rx_s2, rx_prev, rx_fall;
  uart_state_t   rx_state, rx_state_nxt;
  logic [CW-1:0] rx_cnt, rx_cnt_nxt;
  logic [2:0]    rx_bit, rx_bit_nxt;
  logic [7:0]    rx_shift, rx_shift_nxt;
  logic          rx_push;
  logic [7:0]    head;
  logic          not_empty;

  // MMU strobes are levels held for several cycles; act on the rising edge only.
  assign wr_lvl   = bus.enable & (bus.read_write == MEM_WRITE);
  assign rd_lvl   = bus.enable & bus.fetch_data;
  assign wr_pulse = wr_lvl & ~wr_q;
  assign rd_pulse = rd_lvl & ~rd_q;
  assign rx_fall  = rx_prev & ~rx_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_byte  <= '0;
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      wr_q     <= wr_lvl;
      rd_q     <= rd_lvl;
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_byte  <= tx_byte_nxt;
      rx_s1    <= uart_rxd;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_shift <= rx_shift_nxt;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt + 1'b1;
    tx_bit_nxt   = tx_bit;
    tx_byte_nxt  = tx_byte;
    uart_txd     = 1'b1;
    case (tx_state)
      ST_IDLE: begin
        tx_cnt_nxt = '0;
        if (wr_pulse) begin
          tx_state_nxt = ST_START;
          tx_byte_nxt  = bus.data_write;
        end
      end
      ST_START: begin
        uart_txd = 1'b0;
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt   = '0;
          tx_bit_nxt   = '0;
          tx_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        uart_txd = tx_byte[tx_bit];
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt = '0;
          tx_bit_nxt = tx_bit + 1'b1;
          if (tx_bit == 3'd7) tx_state_nxt = ST_STOP;
        end
      end
      default: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt   = '0;
          tx_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // Leaving STOP at its mid-bit sample leaves half a bit to catch the next start edge.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt + 1'b1;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_push      = 1'b0;
    case (rx_state)
      ST_IDLE: begin
        rx_cnt_nxt = '0;
        if (rx_fall) rx_state_nxt = ST_START;
      end
      ST_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_nxt   = '0;
          rx_bit_nxt   = '0;
          rx_state_nxt = rx_s2 ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt   = '0;
          rx_shift_nxt = {rx_s2, rx_shift[7:1]};
          rx_bit_nxt   = rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state_nxt = ST_STOP;
        end
      end
      default: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt   = '0;
          rx_push      = rx_s2;
          rx_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  serial_ctrl_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (rd_pulse),
    .head      (head),
    .not_empty (not_empty),
    .overrun   (rx_overrun)
  );

  assign bus.data_read        = head;
  assign bus.receive_complete = not_empty;
  assign bus.send_complete    = (tx_state == ST_IDLE);

endmodule

// File: tb/tb_serial_ctrl.sv
// tb/tb_serial_ctrl.sv - directed self-checking bench for serial_ctrl (CLKS_PER_BIT=8, RX_DEPTH=4)
module tb_serial_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic uart_rxd = 1'b1;
  logic uart_txd;
  logic rx_overrun;
  logic [9:0] frame;
  int tests = 0;
  int failed = 0;
  int low;

  serial_ctrl_if bus();

  serial_ctrl #(.CLKS_PER_BIT(8), .RX_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .rx_overrun (rx_overrun),
    .uart_txd   (uart_txd),
    .uart_rxd   (uart_rxd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    uart_rxd = 1'b0;
    cycles(8);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      cycles(8);
    end
    uart_rxd = stop;
    cycles(8);
    uart_rxd = 1'b1;
  endtask

  task automatic fetch();
    bus.read_write = 1'b0;
    bus.fetch_data = 1'b1;
    bus.enable     = 1'b1;
    cycles(2);
    bus.enable     = 1'b0;
    bus.fetch_data = 1'b0;
    cycles(2);
  endtask

  initial begin
    bus.enable     = 1'b0;
    bus.read_write = 1'b0;
    bus.fetch_data = 1'b0;
    bus.data_write = 8'h00;
    cycles(3);
    check("rst_txd", uart_txd, 1);
    check("rst_send_complete", bus.send_complete, 1);
    check("rst_receive_complete", bus.receive_complete, 0);
    check("rst_data_read", bus.data_read, 0);
    check("rst_overrun", rx_overrun, 0);
    rst = 1'b1;
    cycles(2);

    // write 8'h41 held 3 cycles, second write 8'h55 mid-frame
    bus.data_write = 8'h41;
    bus.read_write = 1'b1;
    bus.enable     = 1'b1;
    frame = {1'b1, 8'h41, 1'b0};
    low = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 3) bus.enable = 1'b0;
      if (i == 20) begin
        bus.data_write = 8'h55;
        bus.enable     = 1'b1;
      end
      if (i == 23) bus.enable = 1'b0;
      if (!bus.send_complete) low++;
      if (i <= 80 && (i - 1) % 8 == 4)
        check($sformatf("tx_bit%0d", (i - 1) / 8), uart_txd, frame[(i - 1) / 8]);
      if (i > 80 && i % 8 == 0)
        check($sformatf("tx_idle_%0d", i), uart_txd, 1);
    end
    check("tx_low_cycles", low, 80);
    check("tx_send_complete_end", bus.send_complete, 1);

    // single RX frame then fetch
    send_frame(8'hA5, 1'b1);
    cycles(2);
    check("rx_a5_rc", bus.receive_complete, 1);
    check("rx_a5_data", bus.data_read, 8'hA5);
    fetch();
    check("rx_a5_pop_data", bus.data_read, 0);
    check("rx_a5_pop_rc", bus.receive_complete, 0);

    // five frames overflow a four-entry FIFO
    for (int k = 1; k <= 5; k++) send_frame(k[7:0], 1'b1);
    cycles(2);
    check("ovf_flag", rx_overrun, 1);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ovf_head%0d", k), bus.data_read, k);
      fetch();
      if (k == 1) check("ovf_clear", rx_overrun, 0);
    end
    check("ovf_drained_rc", bus.receive_complete, 0);
    check("ovf_drained_data", bus.data_read, 0);

    // glitch and framing error
    uart_rxd = 1'b0;
    cycles(2);
    uart_rxd = 1'b1;
    cycles(20);
    check("glitch_rc", bus.receive_complete, 0);
    send_frame(8'h3C, 1'b0);
    cycles(12);
    check("framing_rc", bus.receive_complete, 0);
    check("framing_data", bus.data_read, 0);
    check("framing_overrun", rx_overrun, 0);

    // reset mid-TX (bit 3) and mid-RX
    bus.data_write = 8'h41;
    bus.read_write = 1'b1;
    bus.enable     = 1'b1;
    uart_rxd       = 1'b0;
    cycles(2);
    bus.enable = 1'b0;
    cycles(34);
    check("mid_tx_bit3", uart_txd, 0);
    check("mid_tx_busy", bus.send_complete, 0);
    rst      = 1'b0;
    uart_rxd = 1'b1;
    #1;
    check("rst_mid_txd", uart_txd, 1);
    check("rst_mid_send_complete", bus.send_complete, 1);
    cycles(2);
    rst = 1'b1;
    cycles(20);
    check("rst_mid_fifo_empty", bus.receive_complete, 0);
    check("rst_mid_txd_idle", uart_txd, 1);
    send_frame(8'h96, 1'b1);
    cycles(2);
    check("post_rst_rc", bus.receive_complete, 1);
    check("post_rst_data", bus.data_read, 8'h96);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
